port_rx_framer: RTL and testbench
=================================

PORT_RX_FRAMER -- requirements
Module: port_rx_framer

Interface
REQ-001 SHALL have parameter PORT_NUB, default 16: switch port count; WIDTH_SEL = clog2(PORT_NUB).
REQ-002 SHALL have parameter DATA_WIDTH, default 64: payload word width.
REQ-003 SHALL have parameter DATA_LENGTH_MAX, default 64: WIDTH_LENGTH = clog2(DATA_LENGTH_MAX); largest legal packet is DATA_LENGTH_MAX-1 payload words.
REQ-004 SHALL have parameter CRC32_LENGTH, default 32: CRC field width (WIDTH_CRC).
REQ-005 SHALL have parameter PRIORITY, default 8: WIDTH_PRIORITY = clog2(PRIORITY); DATA_WIDTH >= WIDTH_LENGTH+WIDTH_CRC+WIDTH_PRIORITY.
REQ-006 clk  in  1  sole clock, rising edge.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 rx_vld  in  1  input word valid.
REQ-009 rx_sop / rx_eop  in  1 each  first / last payload word, qualified by rx_vld.
REQ-010 rx_data  in  DATA_WIDTH  payload word.
REQ-011 rx_dest  in  WIDTH_SEL  destination port, sampled with rx_sop.
REQ-012 rx_priority  in  WIDTH_PRIORITY  priority, sampled with rx_sop.
REQ-013 rx_ready  out  1  framer accepts a word this cycle.
REQ-014 full  in  1  downstream VOQ ingress full (back-pressure).
REQ-015 wr_en_out  out  1  output word valid, drives downstream wr_en_in.
REQ-016 data_out  out  WIDTH_SEL+DATA_WIDTH  {dest, word}.
REQ-017 drop  out  1  one-cycle pulse on a discarded packet.

Function
REQ-018 Input transfer SHALL occur when rx_vld && rx_ready; output transfer when wr_en_out && !full.
REQ-019 FSM states: IDLE, COLLECT, HEADER, PAYLOAD; rx_ready=1 exactly in IDLE and COLLECT.
REQ-020 IDLE: transfer with rx_sop -> latch dest/priority, store word 0, count=1, CRC init; then COLLECT, or HEADER if rx_eop is also set.
REQ-021 IDLE: transfer without rx_sop SHALL be ignored (no store, no drop).
REQ-022 COLLECT: each transfer stores word at index count, count+1, updates CRC; rx_eop -> HEADER next cycle.
REQ-023 COLLECT: a transfer with rx_sop SHALL abort the current packet (drop pulse), then be treated as a new packet start per REQ-020.
REQ-024 Overflow: a store beyond DATA_LENGTH_MAX-1 words SHALL set an overflow flag and discard excess; at rx_eop the packet is dropped (drop pulse), state -> IDLE, nothing emitted.
REQ-025 Buffer: register array of DATA_LENGTH_MAX-1 words, DATA_WIDTH each, single packet.
REQ-026 CRC: CRC-32, poly 0x04C11DB7, init 0xFFFFFFFF, non-reflected, each word processed MSB first, result XORed with 0xFFFFFFFF.
REQ-027 HEADER: wr_en_out=1; data_out = {dest, hdr}.
REQ-028 hdr[WIDTH_LENGTH+WIDTH_CRC+WIDTH_PRIORITY-1 : WIDTH_CRC+WIDTH_PRIORITY] = word count.
REQ-029 hdr[WIDTH_CRC+WIDTH_PRIORITY-1 : WIDTH_PRIORITY] = CRC; hdr[WIDTH_PRIORITY-1:0] = priority; remaining bits 0.
REQ-030 HEADER transfer -> PAYLOAD, read index 0.
REQ-031 PAYLOAD: wr_en_out=1, data_out = {dest, buffer[index]}; each transfer increments index; transfer of word count-1 -> IDLE.
REQ-032 While full=1, state, index and data_out SHALL hold, with wr_en_out kept at 1.
REQ-033 Latency: eop transfer in cycle N -> header on data_out in cycle N+1; with full=0, a packet of L words occupies output cycles N+1..N+1+L; rx_ready returns in cycle N+2+L.
REQ-034 wr_en_out SHALL be 0 in IDLE and COLLECT; drop SHALL not assert in HEADER or PAYLOAD.

Reset
REQ-035 rst_n low SHALL asynchronously force IDLE, count=0, index=0, overflow=0, CRC=0xFFFFFFFF, wr_en_out=0, drop=0, data_out=0, rx_ready=1.
REQ-036 Reset mid-packet SHALL discard the packet without a drop pulse; after release, the first rx_sop starts cleanly.

Verification
REQ-037 3-word packet, dest=5, prio=2, full=0 -> header (length=3, prio=2, CRC matches model, top bits 5), then 3 payload words in order on consecutive cycles.
REQ-038 sop+eop same cycle, 1 word -> header length=1, 1 payload word, rx_ready low for exactly 2 cycles after eop.
REQ-039 full held high for 4 cycles during PAYLOAD word 1 -> data_out stable for those cycles, no word lost or duplicated.
REQ-040 64-word packet (DATA_LENGTH_MAX=64) -> drop pulse at eop, wr_en_out never asserts, next packet framed correctly.
REQ-041 new rx_sop in COLLECT after 2 words -> one drop pulse; only the new packet is emitted.
REQ-042 rst_n low during PAYLOAD -> wr_en_out=0 immediately, IDLE, rx_ready=1.

Source files
------------

// File: rtl/port_rx_framer_if.sv
// Receive-side framing bus: raw packet words in, framed {dest, word} stream out.
interface port_rx_framer_if #(
    parameter int PORT_NUB   = 16,
    parameter int DATA_WIDTH = 64,
    parameter int PRIORITY   = 8
);
    localparam int WIDTH_SEL      = $clog2(PORT_NUB);
    localparam int WIDTH_PRIORITY = $clog2(PRIORITY);

    logic                          rx_vld;
    logic                          rx_sop;
    logic                          rx_eop;
    logic [DATA_WIDTH-1:0]         rx_data;
    logic [WIDTH_SEL-1:0]          rx_dest;
    logic [WIDTH_PRIORITY-1:0]     rx_priority;
    logic                          rx_ready;
    logic                          full;
    logic                          wr_en_out;
    logic [WIDTH_SEL+DATA_WIDTH-1:0] data_out;
    logic                          drop;

    modport slave (
        input  rx_vld, rx_sop, rx_eop, rx_data, rx_dest, rx_priority, full,
        output rx_ready, wr_en_out, data_out, drop
    );

    modport master (
        output rx_vld, rx_sop, rx_eop, rx_data, rx_dest, rx_priority, full,
        input  rx_ready, wr_en_out, data_out, drop
    );
endinterface

// File: rtl/port_rx_framer.sv
// Buffers one packet, computes its CRC-32, then emits a header word
// followed by the payload words toward the VOQ ingress.
module port_rx_framer #(
    parameter int PORT_NUB        = 16,
    parameter int DATA_WIDTH      = 64,
    parameter int DATA_LENGTH_MAX = 64,
    parameter int CRC32_LENGTH    = 32,
    parameter int PRIORITY        = 8
) (
    input logic           clk,
    input logic           rst_n,
    port_rx_framer_if.slave bus
);
    localparam int WIDTH_SEL      = $clog2(PORT_NUB);
    localparam int WIDTH_LENGTH   = $clog2(DATA_LENGTH_MAX);
    localparam int WIDTH_CRC      = CRC32_LENGTH;
    localparam int WIDTH_PRIORITY = $clog2(PRIORITY);
    localparam int DEPTH          = DATA_LENGTH_MAX - 1;

    localparam logic [WIDTH_CRC-1:0]    CRC_POLY = WIDTH_CRC'(32'h04C11DB7);
    localparam logic [WIDTH_CRC-1:0]    CRC_INIT = '1;
    localparam logic [WIDTH_LENGTH-1:0] LAST     = WIDTH_LENGTH'(DEPTH);
    localparam logic [WIDTH_LENGTH-1:0] ONE      = WIDTH_LENGTH'(1);

    typedef enum logic [1:0] {IDLE, COLLECT, HEADER, PAYLOAD} state_e;

    state_e                    state_q, state_d;
    logic [WIDTH_LENGTH-1:0]   count_q, count_d;
    logic [WIDTH_LENGTH-1:0]   idx_q, idx_d;
    logic                      ovf_q, ovf_d;
    logic [WIDTH_CRC-1:0]      crc_q, crc_d;
    logic [WIDTH_SEL-1:0]      dest_q, dest_d;
    logic [WIDTH_PRIORITY-1:0] prio_q, prio_d;
    logic [DATA_WIDTH-1:0]     mem_q [DEPTH];

    logic                      buf_we;
    logic [WIDTH_LENGTH-1:0]   buf_wa;
    logic                      start;
    logic                      in_xfer;
    logic                      out_xfer;
    logic [DATA_WIDTH-1:0]     hdr;

    // Non-reflected, MSB-first shift of one whole word.
    function automatic logic [WIDTH_CRC-1:0] crc_step(
        input logic [WIDTH_CRC-1:0]  c,
        input logic [DATA_WIDTH-1:0] d
    );
        logic [WIDTH_CRC-1:0] r;
        logic                 fb;
        r = c;
        for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
            fb = r[WIDTH_CRC-1] ^ d[i];
            r  = {r[WIDTH_CRC-2:0], 1'b0};
            if (fb) r = r ^ CRC_POLY;
        end
        return r;
    endfunction

    always_comb begin
        bus.rx_ready  = (state_q == IDLE) || (state_q == COLLECT);
        bus.wr_en_out = (state_q == HEADER) || (state_q == PAYLOAD);
        in_xfer       = bus.rx_vld && bus.rx_ready;
        out_xfer      = bus.wr_en_out && !bus.full;
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        idx_d    = idx_q;
        ovf_d    = ovf_q;
        crc_d    = crc_q;
        dest_d   = dest_q;
        prio_d   = prio_q;
        buf_we   = 1'b0;
        buf_wa   = count_q;
        start    = 1'b0;
        bus.drop = 1'b0;
        unique case (state_q)
            IDLE: start = in_xfer && bus.rx_sop;
            COLLECT: begin
                if (in_xfer && bus.rx_sop) begin
                    start    = 1'b1;
                    bus.drop = 1'b1;
                end else if (in_xfer) begin
                    if (count_q < LAST) begin
                        buf_we  = 1'b1;
                        count_d = count_q + ONE;
                        crc_d   = crc_step(crc_q, bus.rx_data);
                    end else begin
                        ovf_d = 1'b1;
                    end
                    if (bus.rx_eop && ovf_d) begin
                        bus.drop = 1'b1;
                        state_d  = IDLE;
                        count_d  = '0;
                        ovf_d    = 1'b0;
                        crc_d    = CRC_INIT;
                    end else if (bus.rx_eop) begin
                        state_d = HEADER;
                    end
                end
            end
            HEADER: begin
                if (out_xfer) begin
                    state_d = PAYLOAD;
                    idx_d   = '0;
                end
            end
            PAYLOAD: begin
                if (out_xfer && idx_q == count_q - ONE) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    count_d = '0;
                    crc_d   = CRC_INIT;
                end else if (out_xfer) begin
                    idx_d = idx_q + ONE;
                end
            end
            default: state_d = IDLE;
        endcase
        // A sop restarts framing whether or not a packet was in progress.
        if (start) begin
            dest_d  = bus.rx_dest;
            prio_d  = bus.rx_priority;
            buf_we  = 1'b1;
            buf_wa  = '0;
            count_d = ONE;
            ovf_d   = 1'b0;
            crc_d   = crc_step(CRC_INIT, bus.rx_data);
            state_d = bus.rx_eop ? HEADER : COLLECT;
        end
    end

    always_comb begin
        hdr = '0;
        hdr[WIDTH_PRIORITY-1:0] = prio_q;
        hdr[WIDTH_PRIORITY +: WIDTH_CRC] = ~crc_q;
        hdr[WIDTH_PRIORITY+WIDTH_CRC +: WIDTH_LENGTH] = count_q;
        bus.data_out = '0;
        if (state_q == HEADER) bus.data_out = {dest_q, hdr};
        if (state_q == PAYLOAD) bus.data_out = {dest_q, mem_q[idx_q]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            idx_q   <= '0;
            ovf_q   <= 1'b0;
            crc_q   <= CRC_INIT;
            dest_q  <= '0;
            prio_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            ovf_q   <= ovf_d;
            crc_q   <= crc_d;
            dest_q  <= dest_d;
            prio_q  <= prio_d;
        end
    end

    // Payload storage needs no reset: only words written this packet are read.
    always_ff @(posedge clk) begin
        if (buf_we) mem_q[buf_wa] <= bus.rx_data;
    end
endmodule

// File: tb/tb_port_rx_framer.sv
// Randomized bench for port_rx_framer against a queue/byte-table reference model.
module tb_port_rx_framer;
    localparam int PN = 16;
    localparam int DW = 64;
    localparam int DLM = 64;
    localparam int CW = 32;
    localparam int PR = 8;
    localparam int WP = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    port_rx_framer_if #(.PORT_NUB(PN), .DATA_WIDTH(DW), .PRIORITY(PR)) bus ();

    port_rx_framer #(
        .PORT_NUB(PN), .DATA_WIDTH(DW), .DATA_LENGTH_MAX(DLM),
        .CRC32_LENGTH(CW), .PRIORITY(PR)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int tests = 0;
    int failed = 0;
    int cyc = 0;
    int drops = 0;
    int wr_cnt = 0;
    int eop_cyc = 0;
    bit full_rand = 1'b0;
    bit full_man = 1'b0;
    logic [67:0] got[$];
    int got_cyc[$];
    logic [67:0] exp[$];

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        bus.full = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.full = full_rand ? ($urandom_range(0, 2) == 0) : full_man;
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (bus.wr_en_out) wr_cnt++;
            if (bus.wr_en_out && !bus.full) begin
                got.push_back(bus.data_out);
                got_cyc.push_back(cyc);
            end
            if (bus.drop) drops++;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog sim time exceeded, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] crc_byte(input logic [7:0] b);
        logic [31:0] c;
        c = {b, 24'h0};
        for (int k = 0; k < 8; k++) c = c[31] ? ((c << 1) ^ 32'h04C11DB7) : (c << 1);
        return c;
    endfunction

    function automatic logic [31:0] ref_crc(input logic [63:0] w[$]);
        logic [31:0] c;
        logic [7:0] b;
        c = 32'hFFFFFFFF;
        foreach (w[i]) begin
            for (int k = 7; k >= 0; k--) begin
                b = w[i][k*8 +: 8];
                c = (c << 8) ^ crc_byte(c[31:24] ^ b);
            end
        end
        return ~c;
    endfunction

    function automatic logic [67:0] ref_hdr(input int len, input logic [31:0] crc,
                                            input logic [3:0] d, input logic [2:0] p);
        logic [63:0] h;
        h = (64'(len) << (CW + WP)) | (64'(crc) << WP) | 64'(p);
        return {d, h};
    endfunction

    function automatic void model_pkt(input logic [63:0] w[$], input logic [3:0] d,
                                      input logic [2:0] p);
        if (w.size() > DLM - 1) return;
        exp.push_back(ref_hdr(w.size(), ref_crc(w), d, p));
        foreach (w[i]) exp.push_back({d, w[i]});
    endfunction

    task automatic drive_word(input logic [63:0] dat, input bit sop, input bit eop,
                              input logic [3:0] d, input logic [2:0] p);
        int n;
        n = 0;
        bus.rx_vld = 1'b1;
        bus.rx_sop = sop;
        bus.rx_eop = eop;
        bus.rx_data = dat;
        bus.rx_dest = d;
        bus.rx_priority = p;
        forever begin
            @(negedge clk);
            if (bus.rx_ready) begin
                if (eop) eop_cyc = cyc;
                break;
            end
            n++;
            if (n > 3000) begin
                tests++;
                failed++;
                $display("FAIL drive_timeout rx_ready=%b required=1", bus.rx_ready);
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.rx_vld = 1'b0;
        bus.rx_sop = 1'b0;
        bus.rx_eop = 1'b0;
    endtask

    task automatic send_pkt(input logic [63:0] w[$], input logic [3:0] d,
                            input logic [2:0] p, input bit gaps, input bit no_eop);
        @(posedge clk);
        #1;
        foreach (w[i]) begin
            if (gaps && $urandom_range(0, 3) == 0)
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clk);
                    #1;
                end
            drive_word(w[i], i == 0, !no_eop && (i == w.size() - 1), d, p);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (bus.rx_ready && !bus.wr_en_out) break;
            n++;
            if (n > 20000) begin
                tests++;
                failed++;
                $display("FAIL idle_timeout rx_ready=%b wr_en_out=%b required=1/0",
                         bus.rx_ready, bus.wr_en_out);
                break;
            end
        end
    endtask

    function automatic void rand_words(output logic [63:0] w[$], input int n);
        w.delete();
        for (int i = 0; i < n; i++) w.push_back({$urandom, $urandom});
    endfunction

    task automatic clear_obs();
        got.delete();
        got_cyc.delete();
        exp.delete();
    endtask

    task automatic test_reset();
        bus.rx_vld = 1'b0;
        bus.rx_sop = 1'b0;
        bus.rx_eop = 1'b0;
        bus.rx_data = '0;
        bus.rx_dest = '0;
        bus.rx_priority = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++;
        if (bus.rx_ready !== 1'b1) begin
            failed++;
            $display("FAIL reset_rx_ready got=%b exp=1", bus.rx_ready);
        end
        tests++;
        if (bus.wr_en_out !== 1'b0) begin
            failed++;
            $display("FAIL reset_wr_en got=%b exp=0", bus.wr_en_out);
        end
        tests++;
        if (bus.drop !== 1'b0) begin
            failed++;
            $display("FAIL reset_drop got=%b exp=0", bus.drop);
        end
        tests++;
        if (bus.data_out !== 68'h0) begin
            failed++;
            $display("FAIL reset_data_out got=%h exp=0", bus.data_out);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (bus.rx_ready !== 1'b1 || bus.wr_en_out !== 1'b0) begin
            failed++;
            $display("FAIL post_reset got rdy=%b wr=%b exp 1/0", bus.rx_ready, bus.wr_en_out);
        end
    endtask

    task automatic test_basic();
        logic [63:0] w[$];
        logic [31:0] c;
        clear_obs();
        rand_words(w, 3);
        c = ref_crc(w);
        model_pkt(w, 4'd5, 3'd2);
        send_pkt(w, 4'd5, 3'd2, 1'b0, 1'b0);
        wait_idle();
        tests++;
        if (got.size() !== 4) begin
            failed++;
            $display("FAIL basic_count got=%0d exp=4", got.size());
        end
        tests++;
        if (got[0][67:64] !== 4'd5 || got[0][40:35] !== 6'd3 || got[0][2:0] !== 3'd2) begin
            failed++;
            $display("FAIL basic_hdr_fields got=%h exp dest=5 len=3 prio=2", got[0]);
        end
        tests++;
        if (got[0][34:3] !== c) begin
            failed++;
            $display("FAIL basic_crc got=%h exp=%h", got[0][34:3], c);
        end
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (got[i] !== exp[i] || got_cyc[i] !== eop_cyc + 1 + i) begin
                failed++;
                $display("FAIL basic_word%0d got=%h@%0d exp=%h@%0d", i, got[i],
                         got_cyc[i], exp[i], eop_cyc + 1 + i);
            end
        end
    endtask

    task automatic test_single();
        logic [63:0] w[$];
        clear_obs();
        rand_words(w, 1);
        model_pkt(w, 4'd9, 3'd7);
        send_pkt(w, 4'd9, 3'd7, 1'b0, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            tests++;
            if (bus.rx_ready !== (i == 3)) begin
                failed++;
                $display("FAIL single_ready_n%0d got=%b exp=%b", i, bus.rx_ready, i == 3);
            end
        end
        wait_idle();
        tests++;
        if (got.size() !== 2 || got[0] !== exp[0] || got[1] !== exp[1]) begin
            failed++;
            $display("FAIL single_seq got=%h,%h exp=%h,%h", got[0], got[1], exp[0], exp[1]);
        end
    endtask

    task automatic test_full_hold();
        logic [63:0] w[$];
        clear_obs();
        rand_words(w, 4);
        model_pkt(w, 4'd3, 3'd1);
        send_pkt(w, 4'd3, 3'd1, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        full_man = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tests++;
            if (bus.data_out !== exp[2] || bus.wr_en_out !== 1'b1) begin
                failed++;
                $display("FAIL full_hold_c%0d got=%h wr=%b exp=%h wr=1", i,
                         bus.data_out, bus.wr_en_out, exp[2]);
            end
        end
        full_man = 1'b0;
        wait_idle();
        tests++;
        if (got.size() !== exp.size()) begin
            failed++;
            $display("FAIL full_hold_count got=%0d exp=%0d", got.size(), exp.size());
        end
        for (int i = 0; i < exp.size(); i++) begin
            tests++;
            if (got[i] !== exp[i]) begin
                failed++;
                $display("FAIL full_hold_word%0d got=%h exp=%h", i, got[i], exp[i]);
            end
        end
    endtask

    task automatic test_overflow();
        logic [63:0] w[$];
        int d0;
        int wr0;
        clear_obs();
        d0 = drops;
        wr0 = wr_cnt;
        rand_words(w, 64);
        send_pkt(w, 4'd1, 3'd4, 1'b0, 1'b0);
        wait_idle();
        tests++;
        if (drops - d0 !== 1 || wr_cnt - wr0 !== 0 || got.size() !== 0) begin
            failed++;
            $display("FAIL overflow_drop got drops=%0d wr=%0d out=%0d exp 1/0/0",
                     drops - d0, wr_cnt - wr0, got.size());
        end
        rand_words(w, 5);
        model_pkt(w, 4'd14, 3'd6);
        send_pkt(w, 4'd14, 3'd6, 1'b1, 1'b0);
        wait_idle();
        tests++;
        if (got.size() !== exp.size()) begin
            failed++;
            $display("FAIL overflow_next_count got=%0d exp=%0d", got.size(), exp.size());
        end
        for (int i = 0; i < exp.size(); i++) begin
            tests++;
            if (got[i] !== exp[i]) begin
                failed++;
                $display("FAIL overflow_next_word%0d got=%h exp=%h", i, got[i], exp[i]);
            end
        end
    endtask

    task automatic test_abort();
        logic [63:0] w[$];
        int d0;
        clear_obs();
        d0 = drops;
        rand_words(w, 2);
        send_pkt(w, 4'd7, 3'd3, 1'b0, 1'b1);
        rand_words(w, 3);
        model_pkt(w, 4'd11, 3'd5);
        send_pkt(w, 4'd11, 3'd5, 1'b0, 1'b0);
        wait_idle();
        tests++;
        if (drops - d0 !== 1) begin
            failed++;
            $display("FAIL abort_drops got=%0d exp=1", drops - d0);
        end
        tests++;
        if (got.size() !== exp.size()) begin
            failed++;
            $display("FAIL abort_count got=%0d exp=%0d", got.size(), exp.size());
        end
        for (int i = 0; i < exp.size(); i++) begin
            tests++;
            if (got[i] !== exp[i]) begin
                failed++;
                $display("FAIL abort_word%0d got=%h exp=%h", i, got[i], exp[i]);
            end
        end
    endtask

    task automatic test_ignore();
        logic [63:0] w[$];
        int d0;
        clear_obs();
        d0 = drops;
        @(posedge clk);
        #1;
        bus.rx_vld = 1'b1;
        bus.rx_sop = 1'b0;
        bus.rx_data = 64'hDEAD_BEEF_0000_0001;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        bus.rx_vld = 1'b0;
        rand_words(w, 2);
        model_pkt(w, 4'd2, 3'd0);
        send_pkt(w, 4'd2, 3'd0, 1'b0, 1'b0);
        wait_idle();
        tests++;
        if (drops - d0 !== 0 || got.size() !== 3) begin
            failed++;
            $display("FAIL ignore_nosop got drops=%0d out=%0d exp 0/3", drops - d0, got.size());
        end
        tests++;
        if (got[0] !== exp[0] || got[2] !== exp[2]) begin
            failed++;
            $display("FAIL ignore_seq got=%h,%h exp=%h,%h", got[0], got[2], exp[0], exp[2]);
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] w[$];
        int d0;
        rand_words(w, 10);
        send_pkt(w, 4'd6, 3'd6, 1'b0, 1'b0);
        d0 = drops;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        tests++;
        if (bus.wr_en_out !== 1'b1) begin
            failed++;
            $display("FAIL mid_pre_wr got=%b exp=1", bus.wr_en_out);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if (bus.wr_en_out !== 1'b0 || bus.rx_ready !== 1'b1 || bus.data_out !== 68'h0) begin
            failed++;
            $display("FAIL mid_reset got wr=%b rdy=%b out=%h exp 0/1/0",
                     bus.wr_en_out, bus.rx_ready, bus.data_out);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_obs();
        rand_words(w, 2);
        model_pkt(w, 4'd8, 3'd2);
        send_pkt(w, 4'd8, 3'd2, 1'b0, 1'b0);
        wait_idle();
        tests++;
        if (drops - d0 !== 0 || got.size() !== 3) begin
            failed++;
            $display("FAIL mid_after got drops=%0d out=%0d exp 0/3", drops - d0, got.size());
        end
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (got[i] !== exp[i]) begin
                failed++;
                $display("FAIL mid_after_word%0d got=%h exp=%h", i, got[i], exp[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [63:0] w[$];
        logic [3:0] d;
        logic [2:0] p;
        int n;
        int d0;
        int ndrop;
        clear_obs();
        d0 = drops;
        ndrop = 0;
        full_rand = 1'b1;
        for (int k = 0; k < 40; k++) begin
            n = ($urandom_range(0, 9) == 0) ? $urandom_range(63, 66) : $urandom_range(1, 12);
            d = 4'($urandom_range(0, 15));
            p = 3'($urandom_range(0, 7));
            rand_words(w, n);
            if (n > DLM - 1) ndrop++;
            model_pkt(w, d, p);
            send_pkt(w, d, p, 1'b1, 1'b0);
        end
        wait_idle();
        full_rand = 1'b0;
        tests++;
        if (drops - d0 !== ndrop) begin
            failed++;
            $display("FAIL rand_drops got=%0d exp=%0d", drops - d0, ndrop);
        end
        tests++;
        if (got.size() !== exp.size()) begin
            failed++;
            $display("FAIL rand_count got=%0d exp=%0d", got.size(), exp.size());
        end
        for (int i = 0; i < exp.size(); i++) begin
            tests++;
            if (got[i] !== exp[i]) begin
                failed++;
                $display("FAIL rand_word%0d got=%h exp=%h", i, got[i], exp[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_single();
        test_full_hold();
        test_overflow();
        test_abort();
        test_ignore();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
